// File: rtl/c17_bist_driver.sv
// ----------------------------------------------------------------------------
// c17_bist_driver
//
// Pattern source and response sink for the c17 benchmark netlist. A 5-bit
// LFSR (x^5+x^3+1) drives the five c17 inputs one pattern per cycle while an
// 8-bit MISR (x^8+x^4+x^3+x^2+1) compacts the two c17 outputs. After
// PAT_COUNT patterns the signature is frozen and compared with GOLDEN_SIG.
//
// Parameters:
//   PAT_COUNT  : patterns applied per run (1..255)
//   LFSR_SEED  : first pattern; zero is replaced by 5'b00001
//   GOLDEN_SIG : expected signature after PAT_COUNT patterns
//
// Ports:
//   CK    in   clock, rising edge
//   RST   in   synchronous active-high reset, overrides everything
//   START in   one-cycle run request (honoured in IDLE and DONE only)
//   PAT   out  [4:0] pattern: [0]=X1 [1]=X2 [2]=X3 [3]=X6 [4]=X7
//   RESP  in   [1:0] c17 response: [0]=X22 [1]=X23
//   BUSY  out  high while patterns are applied (exactly PAT_COUNT cycles)
//   DONE  out  high while SIG holds a completed signature
//   SIG   out  [7:0] MISR contents
//   PASS  out  DONE & (SIG == GOLDEN_SIG)
// ----------------------------------------------------------------------------
module c17_bist_driver #(
    parameter int          PAT_COUNT  = 31,
    parameter logic [4:0]  LFSR_SEED  = 5'b00001,
    parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       START,
    output logic [4:0] PAT,
    input  logic [1:0] RESP,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] SIG,
    output logic       PASS
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [4:0] EFF_SEED = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
    localparam logic [7:0] LAST_CNT = 8'(PAT_COUNT - 1);
    localparam logic [7:0] MISR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     stateReg;
    logic [4:0] patReg;
    logic [7:0] sigReg;
    logic [7:0] cntReg;
    logic       busyReg;
    logic       doneReg;
    logic       passReg;

    logic [4:0] patNext;
    logic [7:0] sigNext;

    // LFSR step: shift left, feedback tap PAT[4]^PAT[2] into bit 0.
    assign patNext = {patReg[3:0], patReg[4] ^ patReg[2]};

    // MISR step, one bit per slice: shifted bit, polynomial feedback from
    // SIG[7], and the response bits folded into the two low positions.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_misr
            logic shiftBit;
            logic respBit;
            if (gi == 0) begin : g_lsb
                assign shiftBit = 1'b0;
            end else begin : g_upper
                assign shiftBit = sigReg[gi-1];
            end
            if (gi < 2) begin : g_resp
                assign respBit = RESP[gi];
            end else begin : g_noresp
                assign respBit = 1'b0;
            end
            assign sigNext[gi] = shiftBit ^ (sigReg[7] & MISR_POLY[gi]) ^ respBit;
        end
    endgenerate

    always_ff @(posedge CK) begin
        if (RST) begin
            stateReg <= ST_IDLE;
            patReg   <= EFF_SEED;
            sigReg   <= 8'h00;
            cntReg   <= 8'd0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            passReg  <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE, ST_DONE: begin
                    // A restart from DONE behaves exactly like one from IDLE.
                    if (START) begin
                        stateReg <= ST_RUN;
                        patReg   <= EFF_SEED;
                        sigReg   <= 8'h00;
                        cntReg   <= 8'd0;
                        busyReg  <= 1'b1;
                        doneReg  <= 1'b0;
                        passReg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The pattern on PAT this cycle produces RESP, which is
                    // captured on this edge; START is ignored here.
                    patReg <= patNext;
                    sigReg <= sigNext;
                    cntReg <= cntReg + 8'd1;
                    if (cntReg == LAST_CNT) begin
                        stateReg <= ST_DONE;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        // Compare against the signature being written now so
                        // PASS is valid on the same cycle DONE rises.
                        passReg  <= (sigNext == GOLDEN_SIG);
                    end
                end
                default: begin
                    stateReg <= ST_IDLE;
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                    passReg  <= 1'b0;
                end
            endcase
        end
    end

    assign PAT  = patReg;
    assign SIG  = sigReg;
    assign BUSY = busyReg;
    assign DONE = doneReg;
    assign PASS = passReg;

endmodule
